// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a 2-FF input synchroniser, false-start rejection and framing-error detection.
// Each bit is sampled at its nominal midpoint; the frame ends at the stop-bit midpoint so back-to-back frames are caught.
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift;

    // Both stages reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bitn        <= '0;
            shift       <= '0;
            rx_msg      <= 8'h00;
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_complete <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == CNT_MID) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= '0;
                            bitn  <= '0;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= '0;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitn <= bitn + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_msg      <= shift;
                            rx_complete <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // A line held low reports one error only; wait for it to return high.
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at CPB=10, HALF=5: directed corner cases, a vector table and random frames.
module tb_uart_rx_byte;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB_TB   = CLK_FREQ / BAUD;
    localparam int HALF_TB  = CPB_TB / 2;
    localparam int BIT_NS   = 100;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       frame_err;
    logic       busy;

    int n_checks;
    int n_fail;
    int n_complete;
    int n_err;
    int cyc;
    int last_complete_cyc;
    logic prev_pulse;

    uart_rx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_msg     (rx_msg),
        .rx_complete(rx_complete),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping and the two pulse-shape rules, observed away from the active edge.
    always @(negedge clk) begin
        if (rx_complete) begin
            n_complete        = n_complete + 1;
            last_complete_cyc = cyc;
        end
        if (frame_err) n_err = n_err + 1;
        if (rx_complete || frame_err) begin
            n_checks = n_checks + 1;
            if ((rx_complete && frame_err) || prev_pulse) begin
                n_fail = n_fail + 1;
                $display("[TB] FAIL pulse_shape: complete=%0b err=%0b prev=%0b, required single isolated pulse",
                         rx_complete, frame_err, prev_pulse);
            end
        end
        prev_pulse = rx_complete | frame_err;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         bit_ns;
        int         gap_ns;
        int         exp_complete;
        int         exp_err;
        logic [7:0] exp_msg;
    } vec_t;

    vec_t vecs[10];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks = n_checks + 1;
        if (actual !== expected) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int bit_ns, input int gap_ns);
        send_frame(data, stop_bit, bit_ns);
        rx = 1'b1;
        if (gap_ns > 0) #(gap_ns);
    endtask

    int c0;
    int base_c;
    int base_e;
    int lat;
    logic [7:0] model_msg;
    logic [7:0] rdata;
    logic rbad;
    int rgap;
    bit exited;

    initial begin
        n_checks = 0; n_fail = 0; n_complete = 0; n_err = 0;
        cyc = 0; last_complete_cyc = 0; prev_pulse = 1'b0;
        rx  = 1'b1;
        rst = 1'b0;

        vecs[0] = '{8'h53, 1'b1, BIT_NS, 0,   1, 0, 8'h53};
        vecs[1] = '{8'h41, 1'b1, BIT_NS, 0,   1, 0, 8'h41};
        vecs[2] = '{8'h4D, 1'b1, BIT_NS, 0,   1, 0, 8'h4D};
        vecs[3] = '{8'h2D, 1'b1, BIT_NS, 0,   1, 0, 8'h2D};
        vecs[4] = '{8'h31, 1'b1, BIT_NS, 0,   1, 0, 8'h31};
        vecs[5] = '{8'h2E, 1'b1, BIT_NS, 200, 1, 0, 8'h2E};
        vecs[6] = '{8'hA5, 1'b1, 97,     200, 1, 0, 8'hA5};
        vecs[7] = '{8'h5A, 1'b1, 103,    200, 1, 0, 8'h5A};
        vecs[8] = '{8'h7E, 1'b0, BIT_NS, 100, 0, 1, 8'h5A};
        vecs[9] = '{8'h00, 1'b1, BIT_NS, 100, 1, 0, 8'h00};

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_msg", int'(rx_msg), 0);
        checkOutput("reset_complete", int'(rx_complete), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single 'S' frame with latency measured from a start edge just after a rising clock edge.
        base_c = n_complete; base_e = n_err;
        @(posedge clk); #2;
        c0 = cyc;
        applyStimulus(8'h53, 1'b1, BIT_NS, 200);
        lat = last_complete_cyc - c0;
        checkOutput("t1_pulses", n_complete - base_c, 1);
        checkOutput("t1_no_err", n_err - base_e, 0);
        checkOutput("t1_msg", int'(rx_msg), 'h53);
        checkOutput("t1_latency_ok",
                    int'(lat >= HALF_TB + 9*CPB_TB + 2 && lat <= HALF_TB + 9*CPB_TB + 4), 1);

        // Glitch of 3 clocks: false start, no pulse, then a good frame.
        base_c = n_complete; base_e = n_err;
        @(posedge clk); #2;
        rx = 1'b0;
        #30;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("t3_busy_during", int'(busy), 1);
        repeat (5) @(negedge clk);
        checkOutput("t3_busy_dropped", int'(busy), 0);
        checkOutput("t3_no_pulse", (n_complete - base_c) + (n_err - base_e), 0);
        applyStimulus(8'h41, 1'b1, BIT_NS, 200);
        checkOutput("t3_msg", int'(rx_msg), 'h41);
        checkOutput("t3_pulses", n_complete - base_c, 1);

        // Stop bit low, line held low: one error, rx_msg retained, busy until line returns high.
        base_c = n_complete; base_e = n_err;
        send_frame(8'h23, 1'b0, BIT_NS);
        #500;
        checkOutput("t4_err_pulses", n_err - base_e, 1);
        checkOutput("t4_no_complete", n_complete - base_c, 0);
        checkOutput("t4_msg_kept", int'(rx_msg), 'h41);
        checkOutput("t4_busy_held", int'(busy), 1);
        rx = 1'b1;
        exited = 1'b0;
        for (int i = 0; i < 20 && !exited; i++) begin
            @(negedge clk);
            if (!busy) exited = 1'b1;
        end
        checkOutput("t4_break_exit", int'(exited), 1);
        checkOutput("t4_err_still_one", n_err - base_e, 1);
        repeat (5) @(negedge clk);

        // Reset during data bit 4 of 0x4D.
        base_c = n_complete; base_e = n_err;
        fork
            send_frame(8'h4D, 1'b1, BIT_NS);
            begin
                #550;
                rst = 1'b0;
                #1;
                checkOutput("t5_rst_msg", int'(rx_msg), 0);
                checkOutput("t5_rst_busy", int'(busy), 0);
                checkOutput("t5_rst_pulses", int'(rx_complete | frame_err), 0);
            end
        join
        rx = 1'b1;
        #20;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_no_pulse", (n_complete - base_c) + (n_err - base_e), 0);
        applyStimulus(8'h2E, 1'b1, BIT_NS, 200);
        checkOutput("t5_msg", int'(rx_msg), 'h2E);

        // Vector table: back-to-back "SAM-1.", +/-3% bit periods, a framing error.
        for (int v = 0; v < 10; v++) begin
            base_c = n_complete; base_e = n_err;
            applyStimulus(vecs[v].data, vecs[v].stop_bit, vecs[v].bit_ns, vecs[v].gap_ns);
            checkOutput($sformatf("vec%0d_complete", v), n_complete - base_c, vecs[v].exp_complete);
            checkOutput($sformatf("vec%0d_err", v), n_err - base_e, vecs[v].exp_err);
            checkOutput($sformatf("vec%0d_msg", v), int'(rx_msg), int'(vecs[v].exp_msg));
        end
        model_msg = vecs[9].exp_msg;

        // Random frames against a "last good byte" reference.
        for (int r = 0; r < 24; r++) begin
            rdata = 8'($urandom);
            rbad  = ($urandom_range(0, 5) == 0);
            rgap  = rbad ? 10 * $urandom_range(3, 15) : 10 * $urandom_range(0, 15);
            base_c = n_complete; base_e = n_err;
            applyStimulus(rdata, !rbad, BIT_NS, rgap);
            if (!rbad) model_msg = rdata;
            checkOutput($sformatf("rnd%0d_complete", r), n_complete - base_c, rbad ? 0 : 1);
            checkOutput($sformatf("rnd%0d_err", r), n_err - base_e, rbad ? 1 : 0);
            checkOutput($sformatf("rnd%0d_msg", r), int'(rx_msg), int'(model_msg));
        end

        repeat (20) @(negedge clk);
        checkOutput("final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
